// File: rtl/hazard_pkg.sv
// Shared types for the hazard/stall controller: FSM states, drain causes, counter width helper.
package hazard_pkg;

  typedef enum logic [1:0] {StRun, StDrain, StSleep} state_e;

  typedef enum logic [1:0] {CauseTrap, CauseMret, CauseWfi} cause_e;

  // Width needed to hold 0..max_long inclusive.
  function automatic int unsigned cnt_w(input int unsigned max_long);
    return $clog2(max_long + 1);
  endfunction

endpackage

// File: rtl/hazard_scoreboard_regs.sv
// Per-register busy bits for out-of-band long ops, outstanding count and operand lookup.
module hazard_scoreboard_regs
  import hazard_pkg::*;
#(
  parameter int unsigned NUM_REGS = 32,
  parameter int unsigned MAX_LONG = 4,
  localparam int unsigned RA_W = $clog2(NUM_REGS),
  localparam int unsigned CNT_W = cnt_w(MAX_LONG)
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_set_en,
  input  logic [RA_W-1:0]  i_set_rd,
  input  logic             i_clr_en,
  input  logic [RA_W-1:0]  i_clr_rd,
  input  logic [RA_W-1:0]  i_rs1,
  input  logic [RA_W-1:0]  i_rs2,
  input  logic [RA_W-1:0]  i_rd,
  output logic             o_hit_rs1,
  output logic             o_hit_rs2,
  output logic             o_hit_rd,
  output logic [CNT_W-1:0] o_count
);

  logic [NUM_REGS-1:0] r_sb;
  logic [NUM_REGS-1:0] w_sb_next;
  logic [CNT_W-1:0]    r_count;
  logic [CNT_W-1:0]    w_count_next;
  logic                w_set;

  assign w_set = i_set_en && (i_set_rd != '0);

  // Set is applied after clear so a same-register collision leaves the bit busy.
  always_comb begin
    w_sb_next = r_sb;
    if (i_clr_en) w_sb_next[i_clr_rd] = 1'b0;
    if (w_set)    w_sb_next[i_set_rd] = 1'b1;
  end

  always_comb begin
    w_count_next = r_count;
    case ({w_set, i_clr_en})
      2'b10:   w_count_next = r_count + CNT_W'(1);
      2'b01:   w_count_next = r_count - CNT_W'(1);
      default: w_count_next = r_count;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_sb    <= '0;
      r_count <= '0;
    end else begin
      r_sb    <= w_sb_next;
      r_count <= w_count_next;
    end
  end

  // Lookups use the registered bits: a same-cycle done does not release the operand.
  assign o_hit_rs1 = r_sb[i_rs1];
  assign o_hit_rs2 = r_sb[i_rs2];
  assign o_hit_rd  = r_sb[i_rd];
  assign o_count   = r_count;

  a_done_on_busy : assert property (@(posedge i_clk) disable iff (i_reset)
    i_clr_en |-> r_sb[i_clr_rd]);
  a_commit_on_free : assert property (@(posedge i_clk) disable iff (i_reset)
    w_set |-> (!r_sb[i_set_rd] || (i_clr_en && (i_clr_rd == i_set_rd))));
  a_no_overflow : assert property (@(posedge i_clk) disable iff (i_reset)
    (w_set && !i_clr_en) |-> (r_count != CNT_W'(MAX_LONG)));
  a_no_underflow : assert property (@(posedge i_clk) disable iff (i_reset)
    (i_clr_en && !w_set) |-> (r_count != '0));

endmodule

// File: rtl/hazard_sb.sv
// Hazard/stall controller with long-op scoreboard and drain/sleep FSM.
// Optional HAZARD_PERF_EN adds free-running 32-bit performance counters.
module hazard_sb
  import hazard_pkg::*;
#(
  parameter int unsigned NUM_REGS = 32,
  parameter int unsigned MAX_LONG = 4,
  localparam int unsigned RA_W = $clog2(NUM_REGS),
  localparam int unsigned CNT_W = cnt_w(MAX_LONG)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid_decode,
  input  logic             uses_rs1,
  input  logic             uses_rs2,
  input  logic             writes_rd_decode,
  input  logic             uses_csr,
  input  logic             long_decode,
  input  logic [RA_W-1:0]  rs1_address_decode,
  input  logic [RA_W-1:0]  rs2_address_decode,
  input  logic [RA_W-1:0]  rd_address_decode,
  input  logic             valid_execute,
  input  logic             csr_write_execute,
  input  logic             bypass_execute,
  input  logic [RA_W-1:0]  rd_address_execute,
  input  logic             valid_memory,
  input  logic             csr_write_memory,
  input  logic             bypass_memory,
  input  logic             branch_taken,
  input  logic             load_store,
  input  logic             mret_memory,
  input  logic [RA_W-1:0]  rd_address_memory,
  input  logic             valid_writeback,
  input  logic             csr_write_writeback,
  input  logic             mret_writeback,
  input  logic             wfi,
  input  logic             trap_req,
  input  logic             long_commit,
  input  logic [RA_W-1:0]  long_commit_rd,
  input  logic             long_done,
  input  logic [RA_W-1:0]  long_done_rd,
  input  logic             interrupt_pending,
  input  logic             fetch_ready,
  input  logic             mem_ready,
  output logic             stall_fetch,
  output logic             stall_decode,
  output logic             stall_execute,
  output logic             stall_memory,
  output logic             invalidate_fetch,
  output logic             invalidate_decode,
  output logic             invalidate_execute,
  output logic             invalidate_memory,
  output logic             trap_ack,
  output logic [CNT_W-1:0] long_outstanding
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0]      perf_hazard_cycles,
  output logic [31:0]      perf_mem_wait_cycles,
  output logic [31:0]      perf_drain_cycles
`endif
);

  state_e r_state, w_state_next;
  cause_e r_cause, w_cause_next;

  logic w_sb_rs1, w_sb_rs2, w_sb_rd;
  logic w_full, w_idle;
  logic w_raw_rs1, w_raw_rs2, w_waw, w_csr_haz, w_data_hazard;
  logic w_mem_wait, w_trap_ack, w_branch_inv;

  hazard_scoreboard_regs #(
    .NUM_REGS (NUM_REGS),
    .MAX_LONG (MAX_LONG)
  ) u_scoreboard (
    .i_clk     (clk),
    .i_reset   (reset),
    .i_set_en  (long_commit),
    .i_set_rd  (long_commit_rd),
    .i_clr_en  (long_done),
    .i_clr_rd  (long_done_rd),
    .i_rs1     (rs1_address_decode),
    .i_rs2     (rs2_address_decode),
    .i_rd      (rd_address_decode),
    .o_hit_rs1 (w_sb_rs1),
    .o_hit_rs2 (w_sb_rs2),
    .o_hit_rd  (w_sb_rd),
    .o_count   (long_outstanding)
  );

  assign w_full = (long_outstanding == CNT_W'(MAX_LONG));
  assign w_idle = (long_outstanding == '0);

  // A nonzero source matching a non-bypassable producer implies that producer's rd != 0.
  assign w_raw_rs1 = uses_rs1 && (rs1_address_decode != '0) &&
      ((valid_execute && !bypass_execute && (rs1_address_decode == rd_address_execute)) ||
       (valid_memory && !bypass_memory && (rs1_address_decode == rd_address_memory)) ||
       w_sb_rs1);
  assign w_raw_rs2 = uses_rs2 && (rs2_address_decode != '0) &&
      ((valid_execute && !bypass_execute && (rs2_address_decode == rd_address_execute)) ||
       (valid_memory && !bypass_memory && (rs2_address_decode == rd_address_memory)) ||
       w_sb_rs2);
  assign w_waw = writes_rd_decode && w_sb_rd;
  assign w_csr_haz = uses_csr && ((valid_execute && csr_write_execute) ||
                                  (valid_memory && csr_write_memory) ||
                                  (valid_writeback && csr_write_writeback));
  assign w_data_hazard = valid_decode &&
      (w_raw_rs1 || w_raw_rs2 || w_waw || w_csr_haz || (long_decode && w_full));

  always_comb begin
    w_state_next = r_state;
    w_cause_next = r_cause;
    w_trap_ack   = 1'b0;
    unique case (r_state)
      StRun: begin
        if (trap_req || mret_writeback) begin
          if (w_idle) begin
            w_trap_ack = 1'b1;
          end else begin
            w_state_next = StDrain;
            w_cause_next = trap_req ? CauseTrap : CauseMret;
          end
        end else if (wfi) begin
          w_state_next = StDrain;
          w_cause_next = CauseWfi;
        end
      end
      StDrain: begin
        if (w_idle) begin
          if (r_cause == CauseWfi) begin
            w_state_next = StSleep;
          end else begin
            w_trap_ack   = 1'b1;
            w_state_next = StRun;
          end
        end
      end
      StSleep: begin
        if (interrupt_pending) w_state_next = StRun;
      end
      default: w_state_next = StRun;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= StRun;
      r_cause <= CauseTrap;
    end else begin
      r_state <= w_state_next;
      r_cause <= w_cause_next;
    end
  end

  // Reset forces every stall low and every invalidate high regardless of held state.
  assign w_mem_wait    = !mem_ready && load_store;
  assign trap_ack      = !reset && w_trap_ack;
  assign w_branch_inv  = branch_taken || trap_ack;
  assign stall_memory  = !reset && (r_state != StRun);
  assign stall_execute = !reset && (stall_memory || w_mem_wait || (valid_memory && mret_memory));
  assign stall_decode  = stall_execute;
  assign stall_fetch   = !reset && (stall_decode || w_data_hazard);

  assign invalidate_fetch   = reset || w_branch_inv || (!fetch_ready && !w_data_hazard);
  assign invalidate_decode  = reset || w_branch_inv || w_data_hazard;
  assign invalidate_execute = reset || w_branch_inv;
  assign invalidate_memory  = reset || trap_ack || w_mem_wait;

`ifdef HAZARD_PERF_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_hazard_cycles   <= '0;
      perf_mem_wait_cycles <= '0;
      perf_drain_cycles    <= '0;
    end else begin
      if (w_data_hazard)        perf_hazard_cycles   <= perf_hazard_cycles + 32'd1;
      if (w_mem_wait)           perf_mem_wait_cycles <= perf_mem_wait_cycles + 32'd1;
      if (r_state == StDrain)   perf_drain_cycles    <= perf_drain_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: doc/hazard_sb.md
Name: hazard_sb

Overview:
Parametrised hazard/stall controller for the 5-stage pipeline (fetch, decode, execute, memory, writeback). It adds a register scoreboard for variable-latency long ops (div/mul unit) that complete out of band after writeback, so the pipeline no longer freezes for them. It also adds optional execute-stage bypass and a drain/sleep state machine that holds trap/mret/wfi until all long ops retire. All stall/invalidate outputs drive the existing stage registers.

Parameters:
NUM_REGS, 32, architectural registers (power of 2); RA_W = clog2(NUM_REGS)
MAX_LONG, 4, max outstanding long ops (>=1); CNT_W = clog2(MAX_LONG+1)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high
valid_decode, uses_rs1, uses_rs2, writes_rd_decode, uses_csr, long_decode  in  1 each  decode qualifiers
rs1_address_decode, rs2_address_decode, rd_address_decode  in  RA_W each  decode operands
valid_execute, csr_write_execute, bypass_execute  in  1 each  execute status (bypass=result forwardable)
rd_address_execute  in  RA_W
valid_memory, csr_write_memory, bypass_memory, branch_taken, load_store, mret_memory  in  1 each
rd_address_memory  in  RA_W
valid_writeback, csr_write_writeback, mret_writeback, wfi, trap_req  in  1 each
long_commit  in  1  long op leaves memory into writeback (non-speculative)
long_commit_rd  in  RA_W
long_done  in  1  long unit writes register file this cycle
long_done_rd  in  RA_W
interrupt_pending  in  1  wake from sleep
fetch_ready, mem_ready  in  1 each  bus handshakes
stall_fetch, stall_decode, stall_execute, stall_memory  out  1 each
invalidate_fetch, invalidate_decode, invalidate_execute, invalidate_memory  out  1 each
trap_ack  out  1  trap/mret redirect granted this cycle
long_outstanding  out  CNT_W  live count of scoreboarded ops

Behaviour:
- Reset: sb[] all 0, count 0, state RUN. While reset=1: all invalidate_*=1, all stall_*=0, trap_ack=0. long_commit/long_done are ignored in reset cycles.
- Scoreboard: sb[r] set at clock edge on long_commit (r=long_commit_rd != 0). Cleared on long_done (r=long_done_rd).
- Simultaneous set and clear of the same r: bit stays 1, count unchanged. Different regs: both apply, count unchanged.
- Count increments on commit only, decrements on done only; saturation is illegal (assertion).
- long_done on a clear bit is an assertion error. long_commit on a set bit is an assertion error (prevented by the WAW stall).
- data_hazard = valid_decode && any of:
  - RAW vs execute when valid_execute, rd!=0, !bypass_execute
  - RAW vs memory when valid_memory, rd!=0, !bypass_memory
  - RAW vs sb[rs1]/sb[rs2] (gated by uses_*, reg!=0); long_done on that reg in the same cycle does NOT release it (1-cycle write latency)
  - WAW: writes_rd_decode && sb[rd_address_decode]
  - uses_csr && any valid csr_write in execute, memory or writeback
  - long_decode && count==MAX_LONG
- Stalls:
  - stall_memory = state!=RUN
  - stall_execute = stall_memory || (!mem_ready && load_store) || (valid_memory && mret_memory)
  - stall_decode = stall_execute
  - stall_fetch = stall_decode || data_hazard
- Redirects:
  - trap_inv = trap_ack
  - branch_inv = branch_taken || trap_inv
  - invalidate_fetch = reset || branch_inv || (!fetch_ready && !data_hazard)
  - invalidate_decode = reset || branch_inv || data_hazard
  - invalidate_execute = reset || branch_inv
  - invalidate_memory = reset || trap_inv || (!mem_ready && load_store)
- FSM:
  - RUN:
    - (trap_req || mret_writeback) && count==0: trap_ack=1 same cycle, stay RUN.
    - (trap_req || mret_writeback) && count!=0: go DRAIN.
    - wfi: go DRAIN.
  - DRAIN:
    - trap_ack=1 in the first cycle count==0 if entered for trap/mret, then RUN. Remembered cause reg; wfi cause goes to SLEEP instead.
    - trap_req has priority over wfi if both are seen at entry.
  - SLEEP: stall held. interrupt_pending -> RUN next cycle.

Optional Feature:
HAZARD_PERF_EN: adds outputs perf_hazard_cycles, perf_mem_wait_cycles, perf_drain_cycles (32 bit each, wrapping, reset 0). They increment on data_hazard, (!mem_ready && load_store), and state==DRAIN respectively. Without the macro these ports and counters are absent and behaviour is otherwise identical.

Decomposition:
- hazard_pkg: state enum {RUN, DRAIN, SLEEP}, cause enum {TRAP, MRET, WFI}, CNT_W helper function.
- Sub-module hazard_scoreboard_regs: sb bit vector, set/clear ports, count, and combinational lookup of rs1/rs2/rd.

Test Plan:
- Reset mid-DRAIN with count=2 -> next cycle state RUN, count 0, sb all 0, invalidate_*=1 during reset.
- long_commit rd=5, then decode rs1=5 -> stall_fetch=1, invalidate_decode=1 until the cycle after long_done rd=5. Same-cycle long_done still stalls.
- long_commit rd=7 and long_done rd=7 same cycle with sb[7]=1 -> sb[7]=1, count unchanged. Then decode writes_rd=7 -> WAW stall.
- MAX_LONG=4, four commits, decode long_decode=1 -> hazard until one long_done, then count 3 and issue proceeds.
- trap_req with count=1 -> stall_memory=1, trap_ack=0; long_done -> trap_ack=1 the next cycle, all invalidates asserted, state RUN.
- wfi with count=0 -> DRAIN one cycle, then SLEEP; interrupt_pending=1 -> RUN and stall_memory=0 the following cycle.
